// File: rtl/accum_core_if.sv
// Board-side bundle for accum_core: program load, run request,
// I/O ports and status outputs.
interface accum_core_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic            prog_we;
   logic [AW-1:0]   prog_addr;
   logic [AW+3:0]   prog_data;
   logic            run;
   logic [DW-1:0]   portin;
   logic [DW-1:0]   portout;
   logic [AW-1:0]   pc;
   logic            busy;
   logic            halted;
   logic            zflag;
   logic            cflag;

   modport master (
      output prog_we, prog_addr, prog_data, run, portin,
      input  portout, pc, busy, halted, zflag, cflag
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, run, portin,
      output portout, pc, busy, halted, zflag, cflag
   );
endinterface

// File: rtl/accum_core.sv
// Accumulator core: 16-opcode ISA, two-cycle fetch/execute,
// loadable program memory and local data memory.
module accum_core #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input logic         clk,
   input logic         PC_reset,
   accum_core_if.slave bus
);
   localparam int IW    = AW + 4;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC,
      HALT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [IW-1:0] ir_q, ir_d;
   logic [DW-1:0] y_q, y_d;
   logic [DW-1:0] y1_q, y1_d;
   logic [DW-1:0] out_q, out_d;
   logic          z_q, z_d;
   logic          c_q, c_d;
   logic          busy_q, busy_d;
   logic          halt_q, halt_d;

   logic [IW-1:0] pm [DEPTH];
   logic [DW-1:0] dm [DEPTH];

   logic [3:0]    op;
   logic [AW-1:0] a;
   logic [DW-1:0] imm;
   logic [DW-1:0] dm_rd;
   logic [DW:0]   sum;
   logic [DW:0]   dif;
   logic          pm_we;
   logic          dm_we;
   logic          set_z;

   assign op    = ir_q[IW-1:AW];
   assign a     = ir_q[AW-1:0];
   assign imm   = DW'(a);
   assign dm_rd = dm[a];
   assign sum   = {1'b0, y_q} + {1'b0, y1_q};
   // top bit of the widened difference is the borrow (Y1 > Y)
   assign dif   = {1'b0, y_q} - {1'b0, y1_q};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      y_d     = y_q;
      y1_d    = y1_q;
      out_d   = out_q;
      z_d     = z_q;
      c_d     = c_q;
      pm_we   = 1'b0;
      dm_we   = 1'b0;
      set_z   = 1'b0;
      unique case (state_q)
         IDLE, HALT: begin
            pm_we = bus.prog_we;
            if (bus.run) begin
               state_d = FETCH;
               pc_d    = '0;
            end
         end
         FETCH: begin
            ir_d    = pm[pc_q];
            pc_d    = pc_q + AW'(1);
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            case (op)
               4'h0: begin
                  y_d   = sum[DW-1:0];
                  c_d   = sum[DW];
                  set_z = 1'b1;
               end
               4'h1: begin
                  y_d   = dif[DW-1:0];
                  c_d   = dif[DW];
                  set_z = 1'b1;
               end
               4'h2: begin
                  y_d   = y_q & y1_q;
                  set_z = 1'b1;
               end
               4'h3: begin
                  y_d   = y_q | y1_q;
                  set_z = 1'b1;
               end
               4'h4: begin
                  y_d   = dm_rd;
                  set_z = 1'b1;
               end
               4'h5: dm_we = 1'b1;
               4'h6: begin
                  y_d   = imm;
                  set_z = 1'b1;
               end
               4'h7: out_d = y_q;
               4'h8: y1_d = y_q;
               4'h9: pc_d = a;
               4'hA: if (z_q) pc_d = a;
               4'hB: if (c_q) pc_d = a;
               4'hC: begin
                  y_d   = bus.portin;
                  set_z = 1'b1;
               end
               4'hD: begin
                  y_d   = y_q ^ y1_q;
                  set_z = 1'b1;
               end
               4'hF: state_d = HALT;
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase
      if (set_z) z_d = (y_d == '0);
      busy_d = (state_d == FETCH) || (state_d == EXEC);
      halt_d = (state_d == HALT);
   end

   always_ff @(posedge clk or posedge PC_reset) begin
      if (PC_reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         y_q     <= '0;
         y1_q    <= '0;
         out_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         y_q     <= y_d;
         y1_q    <= y1_d;
         out_q   <= out_d;
         z_q     <= z_d;
         c_q     <= c_d;
         busy_q  <= busy_d;
         halt_q  <= halt_d;
      end
   end

   // memories keep their contents across reset
   always_ff @(posedge clk) begin
      if (pm_we) pm[bus.prog_addr] <= bus.prog_data;
      if (dm_we) dm[a] <= y_q;
   end

   assign bus.portout = out_q;
   assign bus.pc      = pc_q;
   assign bus.busy    = busy_q;
   assign bus.halted  = halt_q;
   assign bus.zflag   = z_q;
   assign bus.cflag   = c_q;
endmodule

// File: tb/tb_accum_core.sv
// Directed bench for accum_core: reset, arithmetic, branches,
// memory round trip, pc wrap, load lockout and input port.
module tb_accum_core;
   logic clk;
   logic PC_reset;
   int   total;
   int   bad;

   accum_core_if #(.DW(8), .AW(4)) bus ();

   accum_core #(.DW(8), .AW(4)) dut (
      .clk      (clk),
      .PC_reset (PC_reset),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pw(input logic [3:0] addr, input logic [7:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = addr;
      bus.prog_data = data;
      tick();
      bus.prog_we   = 1'b0;
   endtask

   task automatic go();
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (bus.halted === 1'b1) break;
         tick();
      end
      chk(tag, bus.halted, 1);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      PC_reset = 1'b1;
      #1;
      PC_reset = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      PC_reset      = 1'b0;
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.run       = 1'b0;
      bus.portin    = '0;

      // asynchronous reset before any clock edge
      #3 PC_reset = 1'b1;
      #1;
      chk("rst_portout", bus.portout, 0);
      chk("rst_pc", bus.pc, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_z", bus.zflag, 0);
      chk("rst_c", bus.cflag, 0);
      tick();
      PC_reset = 1'b0;
      tick();
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_halted", bus.halted, 0);

      // LDI 5, MOV, LDI 3, ADD, OUT, HALT
      pw(4'd0, 8'h65);
      pw(4'd1, 8'h80);
      pw(4'd2, 8'h63);
      pw(4'd3, 8'h00);
      pw(4'd4, 8'h70);
      pw(4'd5, 8'hF0);
      go();
      chk("add_busy", bus.busy, 1);
      repeat (9) tick();
      chk("add_out_k9", bus.portout, 0);
      tick();
      chk("add_out_k10", bus.portout, 8'h08);
      tick();
      chk("add_halt_k11", bus.halted, 0);
      tick();
      chk("add_halt_k12", bus.halted, 1);
      chk("add_busy_end", bus.busy, 0);
      chk("add_z", bus.zflag, 0);
      chk("add_c", bus.cflag, 0);
      chk("add_pc", bus.pc, 6);

      // LDI 2, MOV, LDI 1, SUB, JC 7, OUT, HALT, OUT, HALT
      pw(4'd0, 8'h62);
      pw(4'd1, 8'h80);
      pw(4'd2, 8'h61);
      pw(4'd3, 8'h10);
      pw(4'd4, 8'hB7);
      pw(4'd5, 8'h70);
      pw(4'd6, 8'hF0);
      pw(4'd7, 8'h70);
      pw(4'd8, 8'hF0);
      go();
      wait_halt("jc_halt", 40);
      chk("jc_out", bus.portout, 8'hFF);
      chk("jc_c", bus.cflag, 1);
      chk("jc_z", bus.zflag, 0);
      chk("jc_pc", bus.pc, 9);

      // LDI 4, ST 15, LDI 0, LD 15, JZ 0, OUT, HALT
      pw(4'd0, 8'h64);
      pw(4'd1, 8'h5F);
      pw(4'd2, 8'h60);
      pw(4'd3, 8'h4F);
      pw(4'd4, 8'hA0);
      pw(4'd5, 8'h70);
      pw(4'd6, 8'hF0);
      go();
      wait_halt("st_halt", 40);
      chk("st_out", bus.portout, 8'h04);
      chk("st_z", bus.zflag, 0);
      chk("st_c_kept", bus.cflag, 1);
      chk("st_pc", bus.pc, 7);

      // LDI 0, ST 15, HALT
      pw(4'd0, 8'h60);
      pw(4'd1, 8'h5F);
      pw(4'd2, 8'hF0);
      go();
      wait_halt("st0_halt", 20);

      // LD 15, JZ 0, OUT, HALT -> loops forever
      pw(4'd0, 8'h4F);
      pw(4'd1, 8'hA0);
      pw(4'd2, 8'h70);
      pw(4'd3, 8'hF0);
      go();
      repeat (3) tick();
      chk("jz_pc_k3", bus.pc, 2);
      tick();
      chk("jz_pc_k4", bus.pc, 0);
      chk("jz_busy", bus.busy, 1);
      repeat (4) tick();
      chk("jz_pc_k8", bus.pc, 0);
      chk("jz_halted", bus.halted, 0);
      chk("jz_out_kept", bus.portout, 8'h04);
      pulse_rst();

      // 16 NOPs: pc wrap and load lockout while busy
      for (int i = 0; i < 16; i++) pw(4'(i), 8'hE0);
      go();
      repeat (30) tick();
      chk("wrap_pc15", bus.pc, 15);
      tick();
      chk("wrap_pc0", bus.pc, 0);
      chk("wrap_busy", bus.busy, 1);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'd0;
      bus.prog_data = 8'hF0;
      repeat (4) tick();
      bus.prog_we   = 1'b0;
      repeat (40) tick();
      chk("lock_halted", bus.halted, 0);
      chk("lock_busy", bus.busy, 1);
      pulse_rst();
      go();
      repeat (4) tick();
      chk("lock_rb_halted", bus.halted, 0);
      chk("lock_rb_busy", bus.busy, 1);
      chk("lock_rb_pc", bus.pc, 2);
      pulse_rst();

      // IN, OUT, HALT with reset during the OUT execute
      bus.portin = 8'hA5;
      pw(4'd0, 8'hC0);
      pw(4'd1, 8'h70);
      pw(4'd2, 8'hF0);
      go();
      wait_halt("in_halt", 20);
      chk("in_out", bus.portout, 8'hA5);
      chk("in_z", bus.zflag, 0);
      go();
      repeat (3) tick();
      chk("in2_busy", bus.busy, 1);
      chk("in2_pc", bus.pc, 2);
      #2 PC_reset = 1'b1;
      #1;
      chk("mid_rst_out", bus.portout, 0);
      chk("mid_rst_pc", bus.pc, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_halted", bus.halted, 0);
      PC_reset = 1'b0;
      repeat (4) tick();
      chk("after_rst_out", bus.portout, 0);
      chk("after_rst_busy", bus.busy, 0);
      chk("after_rst_halted", bus.halted, 0);
      chk("after_rst_pc", bus.pc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
